// File: rtl/dfe_pkg.sv
// ---------------------------------------------------------------------------
// dfe_pkg
// Shared definitions for the digital front-end chain (integrator, comb
// decimator and downstream filter stages).
//   - Default data width and decimation / differential-delay settings
//   - Legal ranges for those settings
//   - Helper for sizing small counters
// ---------------------------------------------------------------------------
package dfe_pkg;

    // Word width shared by the integrator output and the comb input/output
    localparam int DFE_DATA_BW    = 8;

    // Default decimation ratio and its legal range
    localparam int DFE_DECIM_R    = 16;
    localparam int DFE_DECIM_RMIN = 2;
    localparam int DFE_DECIM_RMAX = 256;

    // Default differential delay (in decimated samples) and its legal range
    localparam int DFE_DIFF_M     = 2;
    localparam int DFE_DIFF_MMIN  = 1;
    localparam int DFE_DIFF_MMAX  = 4;

    // Bits needed for a counter running 0..n-1; never less than one bit so
    // that the smallest legal settings still produce a real register
    function automatic int dfeCountBits(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/comb_delay_line.sv
// ---------------------------------------------------------------------------
// comb_delay_line
// DEPTH-deep shift register holding the most recent kept samples of the comb.
// Ports:
//   i_clk     clock, rising edge
//   i_rst     asynchronous active-high reset, clears every entry
//   i_clr     synchronous clear, clears every entry
//   i_shift   load i_data into the newest slot and age all other entries
//   i_data    sample to insert
//   o_oldest  entry inserted DEPTH shifts ago (zero until filled)
// ---------------------------------------------------------------------------
module comb_delay_line
    import dfe_pkg::*;
#(
    parameter int DATA_BW = DFE_DATA_BW,
    parameter int DEPTH   = DFE_DIFF_M
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_shift,
    input  logic [DATA_BW-1:0] i_data,
    output logic [DATA_BW-1:0] o_oldest
);

    logic [DATA_BW-1:0] r_line [DEPTH];

    // Slot 0 is the newest entry, slot DEPTH-1 the oldest. Clear has
    // priority over shift so a disable always leaves zero history.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_line[i] <= '0;
            end
        end else if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_line[i] <= '0;
            end
        end else if (i_shift) begin
            r_line[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    assign o_oldest = r_line[DEPTH-1];

endmodule

// File: rtl/comb_decimator.sv
// ---------------------------------------------------------------------------
// comb_decimator
// CIC comb-and-decimate stage fed by the wrapping running sum of the
// integrator. Keeps every DECIM_R-th accepted sample and outputs the modular
// difference against the sample kept DIFF_M decimated steps earlier.
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-high reset
//   en_i      stage enable; low clears all state at the next edge
//   data_i    integrator running sum (two's complement, wrapping)
//   valid_i   data_i qualifier
//   data_o    registered comb difference, held between pulses
//   valid_o   one-cycle pulse per decimated output
//   primed_o  high once DIFF_M samples have been kept since enable/reset
// ---------------------------------------------------------------------------
module comb_decimator
    import dfe_pkg::*;
#(
    parameter int DATA_BW = DFE_DATA_BW,
    parameter int DECIM_R = DFE_DECIM_R,
    parameter int DIFF_M  = DFE_DIFF_M
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [DATA_BW-1:0] data_i,
    input  logic               valid_i,
    output logic [DATA_BW-1:0] data_o,
    output logic               valid_o,
    output logic               primed_o
);

    localparam int CW = dfeCountBits(DECIM_R);
    localparam int PW = dfeCountBits(DIFF_M + 1);
    localparam logic [CW-1:0] DECIM_LAST = CW'(DECIM_R - 1);
    localparam logic [PW-1:0] PRIME_FULL = PW'(DIFF_M);

    logic [CW-1:0]      r_decimCnt;
    logic [PW-1:0]      r_primeCnt;
    logic [DATA_BW-1:0] r_data;
    logic               r_valid;

    logic               w_accept;
    logic               w_keep;
    logic [DATA_BW-1:0] w_oldest;
    logic [DATA_BW-1:0] w_diff;

    assign w_accept = en_i & valid_i;
    assign w_keep   = w_accept & (r_decimCnt == DECIM_LAST);

    // Plain DATA_BW-bit subtraction: the integrator wraps, so the carry is
    // meaningless and must be dropped rather than saturated
    assign w_diff   = data_i - w_oldest;

    comb_delay_line #(
        .DATA_BW (DATA_BW),
        .DEPTH   (DIFF_M)
    ) u_delay (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_clr    (~en_i),
        .i_shift  (w_keep),
        .i_data   (data_i),
        .o_oldest (w_oldest)
    );

    // Decimation counter, prime counter and output registers. A low enable
    // wins over a simultaneous valid sample and restarts the stage as if
    // from reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_decimCnt <= '0;
            r_primeCnt <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else if (!en_i) begin
            r_decimCnt <= '0;
            r_primeCnt <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= w_keep;
            if (w_accept) begin
                r_decimCnt <= w_keep ? '0 : r_decimCnt + 1'b1;
            end
            if (w_keep) begin
                r_data <= w_diff;
                if (r_primeCnt != PRIME_FULL) begin
                    r_primeCnt <= r_primeCnt + 1'b1;
                end
            end
        end
    end

    assign data_o   = r_data;
    assign valid_o  = r_valid;
    assign primed_o = (r_primeCnt == PRIME_FULL);

endmodule
